// File: rtl/entry_pwd_check_pkg.sv
// entry_pwd_check_pkg: shared state encodings and default sizing for the entry password check.
package entry_pwd_check_pkg;
    localparam int N_SLOTS     = 8;
    localparam int DIGIT_W     = 4;
    localparam int PWD_DIGITS  = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;
    localparam int TIMEOUT     = 64;
    typedef enum logic [1:0] {
        S_IDLE,
        S_GET_PWD,
        S_CHECK,
        S_LOCKOUT
    } state_t;
endpackage

// File: rtl/entry_pwd_check_pwd_store.sv
// entry_pwd_check_pwd_store: per-flat password words with reset-cleared programmed bits.
module entry_pwd_check_pwd_store #(
    parameter int N     = 8,
    parameter int PWD_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [N:0]       wflat,
    input  logic [PWD_W-1:0] wpwd,
    input  logic [N:0]       rflat,
    output logic [PWD_W-1:0] rd_pwd,
    output logic             rd_prog
);
    logic [PWD_W-1:0] r_pwd [N];
    logic [N-1:0]     r_prog;
    // Words carry no reset; only the programmed bits gate whether a word is trusted.
    always_ff @(posedge clk)
        for (int i = 0; i < N; i++)
            if (we && wflat == (N+1)'(i + 1))
                r_pwd[i] <= wpwd;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_prog <= '0;
        else
            for (int i = 0; i < N; i++)
                if (we && wflat == (N+1)'(i + 1))
                    r_prog[i] <= 1'b1;
    always_comb begin
        rd_pwd  = '0;
        rd_prog = 1'b0;
        for (int i = 0; i < N; i++)
            if (rflat == (N+1)'(i + 1)) begin
                rd_pwd  = r_pwd[i];
                rd_prog = r_prog[i];
            end
    end
endmodule

// File: rtl/entry_pwd_check.sv
// entry_pwd_check: serial keypad password check per flat with retry limit, lockout and entry timeout.
module entry_pwd_check
    import entry_pwd_check_pkg::*;
#(
    parameter int N           = N_SLOTS,
    parameter int PWD_DIGITS  = entry_pwd_check_pkg::PWD_DIGITS,
    parameter int MAX_TRIES   = entry_pwd_check_pkg::MAX_TRIES,
    parameter int LOCK_CYCLES = entry_pwd_check_pkg::LOCK_CYCLES,
    parameter int TIMEOUT     = entry_pwd_check_pkg::TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flat_valid,
    input  logic [N:0]                    flat_in,
    input  logic                          key_valid,
    input  logic [DIGIT_W-1:0]            key_digit,
    input  logic                          key_enter,
    input  logic                          cfg_we,
    input  logic [N:0]                    cfg_flat,
    input  logic [DIGIT_W*PWD_DIGITS-1:0] cfg_pwd,
    output logic                          out_valid,
    output logic                          pwd_flag,
    output logic [N:0]                    flat_number,
    output logic                          bad_attempt,
    output logic                          bad_flat,
    output logic                          locked,
    output logic                          ready
);
    localparam int PWD_W  = DIGIT_W * PWD_DIGITS;
    localparam int DCNT_W = $clog2(PWD_DIGITS + 2);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int LCK_W  = $clog2(LOCK_CYCLES + 1);

    state_t             r_state;
    logic [N:0]         r_flat;
    logic [PWD_W-1:0]   r_shift;
    logic [DCNT_W-1:0]  r_dcnt;
    logic [TRY_W-1:0]   r_tries;
    logic [TMR_W-1:0]   r_timer;
    logic [LCK_W-1:0]   r_lock_cnt;
    logic [PWD_W-1:0]   w_rd_pwd;
    logic               w_rd_prog;
    logic               w_flat_ok;
    logic               w_digit_ok;
    logic               w_match;
    logic               w_last_try;

    entry_pwd_check_pwd_store #(.N(N), .PWD_W(PWD_W)) u_store (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_we),
        .wflat   (cfg_flat),
        .wpwd    (cfg_pwd),
        .rflat   (r_flat),
        .rd_pwd  (w_rd_pwd),
        .rd_prog (w_rd_prog)
    );

    assign w_flat_ok  = flat_in != '0 && flat_in <= (N+1)'(N);
    assign w_digit_ok = key_digit <= DIGIT_W'(9);
    // Digit count saturates past PWD_DIGITS so over-long entries can never match.
    assign w_match    = w_rd_prog && r_dcnt == DCNT_W'(PWD_DIGITS) && r_shift == w_rd_pwd;
    assign w_last_try = r_tries == TRY_W'(MAX_TRIES - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state     <= S_IDLE;
            r_flat      <= '0;
            r_shift     <= '0;
            r_dcnt      <= '0;
            r_tries     <= '0;
            r_timer     <= '0;
            r_lock_cnt  <= '0;
            out_valid   <= 1'b0;
            pwd_flag    <= 1'b0;
            flat_number <= '0;
            bad_attempt <= 1'b0;
            bad_flat    <= 1'b0;
            locked      <= 1'b0;
            ready       <= 1'b1;
        end else begin
            out_valid   <= 1'b0;
            bad_attempt <= 1'b0;
            bad_flat    <= 1'b0;
            case (r_state)
                S_IDLE:
                    if (flat_valid) begin
                        if (w_flat_ok) begin
                            r_flat  <= flat_in;
                            r_shift <= '0;
                            r_dcnt  <= '0;
                            r_tries <= '0;
                            r_timer <= '0;
                            ready   <= 1'b0;
                            r_state <= S_GET_PWD;
                        end else
                            bad_flat <= 1'b1;
                    end
                S_GET_PWD:
                    if (key_enter)
                        r_state <= S_CHECK;
                    else if (key_valid && w_digit_ok) begin
                        r_shift <= {r_shift[PWD_W-DIGIT_W-1:0], key_digit};
                        r_dcnt  <= r_dcnt == DCNT_W'(PWD_DIGITS + 1) ? r_dcnt : r_dcnt + DCNT_W'(1);
                        r_timer <= '0;
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        ready   <= 1'b1;
                        r_state <= S_IDLE;
                    end else
                        r_timer <= r_timer + TMR_W'(1);
                S_CHECK:
                    if (w_match) begin
                        out_valid   <= 1'b1;
                        pwd_flag    <= 1'b1;
                        flat_number <= r_flat;
                        ready       <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_last_try) begin
                        out_valid   <= 1'b1;
                        pwd_flag    <= 1'b0;
                        flat_number <= r_flat;
                        locked      <= 1'b1;
                        r_lock_cnt  <= '0;
                        r_state     <= S_LOCKOUT;
                    end else begin
                        bad_attempt <= 1'b1;
                        r_tries     <= r_tries + TRY_W'(1);
                        r_shift     <= '0;
                        r_dcnt      <= '0;
                        r_timer     <= '0;
                        r_state     <= S_GET_PWD;
                    end
                S_LOCKOUT:
                    if (r_lock_cnt == LCK_W'(LOCK_CYCLES - 1)) begin
                        locked  <= 1'b0;
                        ready   <= 1'b1;
                        r_state <= S_IDLE;
                    end else
                        r_lock_cnt <= r_lock_cnt + LCK_W'(1);
                default:
                    r_state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_entry_pwd_check.sv
// tb_entry_pwd_check: directed vectors with hand-computed verdicts for entry_pwd_check.
module tb_entry_pwd_check;
    localparam int N = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flat_valid = 1'b0;
    logic [N:0]  flat_in = '0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = '0;
    logic        key_enter = 1'b0;
    logic        cfg_we = 1'b0;
    logic [N:0]  cfg_flat = '0;
    logic [15:0] cfg_pwd = '0;
    logic        out_valid, pwd_flag, bad_attempt, bad_flat, locked, ready;
    logic [N:0]  flat_number;
    int          errors = 0;
    int          checks = 0;

    entry_pwd_check #(.N(N)) dut (
        .clk(clk), .rst(rst), .flat_valid(flat_valid), .flat_in(flat_in),
        .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter),
        .cfg_we(cfg_we), .cfg_flat(cfg_flat), .cfg_pwd(cfg_pwd),
        .out_valid(out_valid), .pwd_flag(pwd_flag), .flat_number(flat_number),
        .bad_attempt(bad_attempt), .bad_flat(bad_flat), .locked(locked), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic program_flat(input int f, input logic [15:0] pwd);
        cfg_we = 1'b1; cfg_flat = (N+1)'(f); cfg_pwd = pwd;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic enter_flat(input int f);
        flat_valid = 1'b1; flat_in = (N+1)'(f);
        tick();
        flat_valid = 1'b0;
    endtask

    task automatic keys(input logic [15:0] digits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            key_valid = 1'b1; key_digit = digits[i*4 +: 4];
            tick();
        end
        key_valid = 1'b0;
    endtask

    task automatic submit(input string tag, input logic with_key, input logic exp_ov,
                          input logic exp_pf, input logic exp_ba);
        key_enter = 1'b1; key_valid = with_key; key_digit = 4'd9;
        tick();
        key_enter = 1'b0; key_valid = 1'b0;
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_ov"}, {31'd0, out_valid}, {31'd0, exp_ov});
        check({tag, "_ba"}, {31'd0, bad_attempt}, {31'd0, exp_ba});
        if (exp_ov) check({tag, "_pf"}, {31'd0, pwd_flag}, {31'd0, exp_pf});
    endtask

    task automatic wait_unlock(input string tag, input int exp_cycles);
        int n = 0;
        while (locked && n < 40) begin
            n++;
            flat_valid = (n == 1); flat_in = (N+1)'(3);
            tick();
        end
        flat_valid = 1'b0;
        check({tag, "_lock_len"}, n, exp_cycles);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_ov", {31'd0, out_valid}, 32'd0);
        check("rst_pf", {31'd0, pwd_flag}, 32'd0);
        check("rst_ba", {31'd0, bad_attempt}, 32'd0);
        check("rst_bf", {31'd0, bad_flat}, 32'd0);
        check("rst_lk", {31'd0, locked}, 32'd0);
        check("rst_fn", 32'(flat_number), 32'd0);
        check("rst_rdy", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        tick();
        program_flat(3, 16'h1234);
        enter_flat(3);
        check("sess_rdy", {31'd0, ready}, 32'd0);
        keys(16'h1234, 4);
        submit("good", 1'b0, 1'b1, 1'b1, 1'b0);
        check("good_fn", 32'(flat_number), 32'd3);
        tick();
        check("good_rdy", {31'd0, ready}, 32'd1);
        check("good_ov_once", {31'd0, out_valid}, 32'd0);
        enter_flat(3);
        keys(16'h1235, 4);
        submit("wrong1", 1'b0, 1'b0, 1'b0, 1'b1);
        keys(16'h1235, 4);
        submit("wrong2", 1'b0, 1'b0, 1'b0, 1'b1);
        keys(16'h1235, 4);
        submit("wrong3", 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrong3_lk", {31'd0, locked}, 32'd1);
        wait_unlock("lock", 16);
        enter_flat(3);
        keys(16'h0123, 3);
        submit("short", 1'b0, 1'b0, 1'b0, 1'b1);
        keys(16'h2344, 5);
        submit("long", 1'b0, 1'b0, 1'b0, 1'b1);
        keys(16'h1234, 4);
        submit("third_ok", 1'b0, 1'b1, 1'b1, 1'b0);
        enter_flat(0);
        check("flat0_bf", {31'd0, bad_flat}, 32'd1);
        check("flat0_rdy", {31'd0, ready}, 32'd1);
        tick();
        check("flat0_bf_pulse", {31'd0, bad_flat}, 32'd0);
        enter_flat(N + 1);
        check("flatN1_bf", {31'd0, bad_flat}, 32'd1);
        check("flatN1_ov", {31'd0, out_valid}, 32'd0);
        enter_flat(5);
        keys(16'h1234, 4);
        submit("unprog1", 1'b0, 1'b0, 1'b0, 1'b1);
        keys(16'h0000, 4);
        submit("unprog2", 1'b0, 1'b0, 1'b0, 1'b1);
        keys(16'h9999, 4);
        submit("unprog3", 1'b0, 1'b1, 1'b0, 1'b0);
        check("unprog3_fn", 32'(flat_number), 32'd5);
        wait_unlock("lock5", 16);
        enter_flat(3);
        keys(16'h0001, 1);
        repeat (63) tick();
        check("tmo_before", {31'd0, ready}, 32'd0);
        tick();
        check("tmo_rdy", {31'd0, ready}, 32'd1);
        check("tmo_ov", {31'd0, out_valid}, 32'd0);
        enter_flat(3);
        keys(16'h1234, 4);
        submit("enter_wins", 1'b1, 1'b1, 1'b1, 1'b0);
        enter_flat(3);
        keys(16'h0012, 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rdy", {31'd0, ready}, 32'd1);
        check("mid_rst_fn", 32'(flat_number), 32'd0);
        check("mid_rst_pf", {31'd0, pwd_flag}, 32'd0);
        rst = 1'b0;
        tick();
        enter_flat(3);
        keys(16'h1234, 4);
        submit("after_rst", 1'b0, 1'b0, 1'b0, 1'b1);
        program_flat(3, 16'h1234);
        keys(16'h1234, 4);
        submit("reprog", 1'b0, 1'b1, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
